seq_gen: RTL

Serial test-pattern transmitter: captures a WIDTH-bit pattern on a start request and drives it MSB-first onto the single-bit line W, holding each bit for DIV clock cycles. It is the sending end of the serial W stream consumed by the team's sequence/transition detector. On the board it replaces the manually pushed W switch, so detector experiments run from a known, repeatable bit stream.

---
 rtl/seq_gen_pkg.sv | 19 +
 rtl/seq_gen_bit_tick.sv | 47 ++++
 rtl/seq_gen.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and parameter defaults for the serial
// test-pattern transmitter.
package seq_gen_pkg;

  // Frame-level controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Board defaults: 8-bit pattern, each bit held for 10000 MHz cycles.
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DIV_DEF   = 10000;

  // Short bit time used in simulation so a frame fits in a few dozen cycles.
  localparam int unsigned DIV_SIM   = 4;

endpackage : seq_gen_pkg

// File: rtl/seq_gen_bit_tick.sv
// bit_tick: free-running bit-time divider. Counts 0..DIV-1 and raises a
// one-cycle tick while the count sits at DIV-1. A synchronous clear holds
// the count at zero so the first bit of a frame gets a full DIV cycles.
module bit_tick
  import seq_gen_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;
  logic          tick_q,  tick_d;

  // Next count: clear wins, otherwise wrap explicitly at DIV-1.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
    tick_d = (count_d == LAST);
  end

  // Divider state and registered tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule : bit_tick

// File: rtl/seq_gen.sv
// seq_gen: captures a WIDTH-bit pattern on start and sends it MSB-first on
// w_o, each bit held DIV cycles; optionally repeats the captured frame.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIV   = DIV_DEF
) (
  input  logic             mhz_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic             repeat_i,
  output logic             w_o,
  output logic             bit_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic [IW-1:0]    idx_q,   idx_d;
  logic             w_q,     w_d;
  logic             bv_q,    bv_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic             tick_s;
  logic             div_clr_s;

  // The divider only runs while a frame is on the line, so it restarts
  // from zero on every accepted start.
  assign div_clr_s = (state_q != SHIFT);

  bit_tick #(
    .DIV (DIV)
  ) u_bit_tick (
    .clk_i  (mhz_i),
    .rst_i  (reset_i),
    .clr_i  (div_clr_s),
    .tick_o (tick_s)
  );

  // Next-state and next-output logic for the frame controller.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    w_d     = w_q;
    bv_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      // DONE shares IDLE's accept path: its closing edge is the first edge
      // that may take a new start, giving a one-cycle gap between frames.
      // A start seen while DONE's pulse is still being set up is not queued.
      IDLE, DONE: begin
        w_d    = 1'b0;
        busy_d = 1'b0;
        if (start_i) begin
          shreg_d = pattern_i;
          frame_d = pattern_i;
          idx_d   = '0;
          w_d     = pattern_i[WIDTH-1];
          bv_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        busy_d = 1'b1;
        if (tick_s) begin
          if (idx_q != LAST_IDX) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            w_d     = shreg_q[WIDTH-2];
            bv_d    = 1'b1;
            idx_d   = idx_q + IW'(1);
          end else if (repeat_i) begin
            // Repeats always come from the frame copy, never the live input.
            shreg_d = frame_q;
            w_d     = frame_q[WIDTH-1];
            bv_d    = 1'b1;
            idx_d   = '0;
          end else begin
            shreg_d = '0;
            idx_d   = '0;
            w_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          state_d = SHIFT;
        end
      end

      default: begin
        shreg_d = '0;
        idx_d   = '0;
        w_d     = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge mhz_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      frame_q <= '0;
      idx_q   <= '0;
      w_q     <= 1'b0;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      bv_q    <= bv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w_o         = w_q;
  assign bit_valid_o = bv_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule : seq_gen
